// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment dimmer: Avalon register addresses,
// the active-low blank pattern, the full-brightness duty value and the last
// PWM step index. Imported by seg7_pwm_timebase and seg7_dimmer.
// ----------------------------------------------------------------------------
package seg7_pkg;

    // Register map (2-bit Avalon word address)
    localparam logic [1:0] SEG7_ADDR_CONTROL   = 2'd0;
    localparam logic [1:0] SEG7_ADDR_DUTY      = 2'd1;
    localparam logic [1:0] SEG7_ADDR_BLINK_DIV = 2'd2;
    localparam logic [1:0] SEG7_ADDR_STATUS    = 2'd3;

    // Segments are active-low, so all ones is a dark digit.
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Duty reset value; anything at or above this keeps the digit fully lit.
    localparam logic [4:0] SEG7_DUTY_FULL = 5'd16;

    // Last of the 16 PWM steps in a frame.
    localparam logic [3:0] SEG7_STEP_MAX = 4'd15;

endpackage : seg7_pkg

// File: rtl/seg7_pwm_timebase.sv
// ----------------------------------------------------------------------------
// seg7_pwm_timebase
// Free-running PWM timebase: a prescaler divides clk by PWM_DIV to produce
// one tick per PWM step, a 4-bit step counter walks 0..15 per frame, and
// frame_end flags the tick that closes a frame.
//
// Parameters:
//   PWM_DIV    clk cycles per PWM step (2..65535)
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   tick       high for the last clk of each PWM step
//   step       current PWM step, 0..15
//   frame_end  high for the last clk of each 16-step frame
// ----------------------------------------------------------------------------
module seg7_pwm_timebase
    import seg7_pkg::*;
#(
    parameter int unsigned PWM_DIV = 3125
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       tick,
    output logic [3:0] step,
    output logic       frame_end
);

    localparam logic [15:0] PCNT_LAST = 16'(PWM_DIV - 1);

    logic [15:0] pcnt_q, pcnt_d;
    logic [3:0]  step_q, step_d;

    assign tick      = (pcnt_q == PCNT_LAST);
    assign frame_end = tick && (step_q == SEG7_STEP_MAX);
    assign step      = step_q;

    always_comb begin
        pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
        // step wraps 15 -> 0 naturally in 4 bits.
        step_d = tick ? step_q + 4'd1 : step_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the blocks are evaluated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= 16'd0;
            step_q <= 4'd0;
        end else begin
            pcnt_q <= pcnt_d;
            step_q <= step_d;
        end
    end

endmodule : seg7_pwm_timebase

// File: rtl/seg7_dimmer.sv
// ----------------------------------------------------------------------------
// seg7_dimmer
// Avalon-MM slave placed between a seven-segment PIO out_port and the HEX
// pins. Registers the active-low segment pattern and gates it with a 16-step
// PWM brightness control and optional blinking.
//
// Build option:
//   SEG7_DIMMER_BLINK_EN  when defined, the blink logic (CONTROL bit1,
//                         BLINK_DIV, blink counter, phase) is built; when not
//                         defined, phase is a constant 1 and those register
//                         bits read 0 and ignore writes.
//
// Parameters:
//   PWM_DIV     clk cycles per PWM step (2..65535)
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 CONTROL, 1 DUTY, 2 BLINK_DIV, 3 STATUS)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, combinational, unused bits 0
//   seg_in      segment pattern from the PIO, active-low
//   hex_out     registered segment drive to the pins, active-low
// ----------------------------------------------------------------------------
module seg7_dimmer
    import seg7_pkg::*;
#(
    parameter int unsigned PWM_DIV = 3125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [6:0]  seg_in,
    output logic [6:0]  hex_out
);

    logic       wr_en;
    logic       tick;
    logic [3:0] step;
    logic       frame_end;
    logic       phase;
    logic       lit;

    logic       enable_q, enable_d;
    logic [4:0] duty_q, duty_d;
    logic [6:0] hex_out_q;

    assign wr_en = chipselect && !write_n;

    seg7_pwm_timebase #(
        .PWM_DIV   (PWM_DIV)
    ) u_timebase (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .step      (step),
        .frame_end (frame_end)
    );

    // ------------------------------------------------------------------
    // Brightness registers
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default before any
    // branch; otherwise an unassigned path infers a latch.
    always_comb begin
        enable_d = enable_q;
        duty_d   = duty_q;
        if (wr_en && address == SEG7_ADDR_CONTROL) enable_d = writedata[0];
        if (wr_en && address == SEG7_ADDR_DUTY)    duty_d   = writedata[4:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= 1'b1;
            duty_q   <= SEG7_DUTY_FULL;
        end else begin
            enable_q <= enable_d;
            duty_q   <= duty_d;
        end
    end

    // ------------------------------------------------------------------
    // Blink logic
    // ------------------------------------------------------------------
`ifdef SEG7_DIMMER_BLINK_EN
    logic        blink_en_q, blink_en_d;
    logic [15:0] blink_div_q, blink_div_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic        phase_q, phase_d;

    always_comb begin
        blink_en_d  = blink_en_q;
        blink_div_d = blink_div_q;
        bcnt_d      = bcnt_q;
        phase_d     = phase_q;

        if (wr_en && address == SEG7_ADDR_CONTROL) blink_en_d = writedata[1];

        // A BLINK_DIV write restarts the blink cycle in the on phase and
        // takes priority over a coincident frame_end.
        if (wr_en && address == SEG7_ADDR_BLINK_DIV) begin
            blink_div_d = writedata[15:0];
            bcnt_d      = 16'd0;
            phase_d     = 1'b1;
        end else if (!blink_en_q) begin
            bcnt_d  = 16'd0;
            phase_d = 1'b1;
        end else if (frame_end) begin
            if (blink_div_q != 16'd0 && bcnt_q == blink_div_q - 16'd1) begin
                bcnt_d  = 16'd0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_en_q  <= 1'b0;
            blink_div_q <= 16'd0;
            bcnt_q      <= 16'd0;
            phase_q     <= 1'b1;
        end else begin
            blink_en_q  <= blink_en_d;
            blink_div_q <= blink_div_d;
            bcnt_q      <= bcnt_d;
            phase_q     <= phase_d;
        end
    end

    assign phase = phase_q;
`else
    assign phase = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    // Zero-extend step so duty values 16..31 compare as always-on.
    assign lit = enable_q && phase && ({1'b0, step} < duty_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_out_q <= SEG7_BLANK;
        end else begin
            hex_out_q <= lit ? seg_in : SEG7_BLANK;
        end
    end

    assign hex_out = hex_out_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        readdata = 32'd0;
        case (address)
            SEG7_ADDR_CONTROL: begin
                readdata[0] = enable_q;
`ifdef SEG7_DIMMER_BLINK_EN
                readdata[1] = blink_en_q;
`endif
            end
            SEG7_ADDR_DUTY: begin
                readdata[4:0] = duty_q;
            end
            SEG7_ADDR_BLINK_DIV: begin
`ifdef SEG7_DIMMER_BLINK_EN
                readdata[15:0] = blink_div_q;
`endif
            end
            SEG7_ADDR_STATUS: begin
                readdata[7:4] = step;
                readdata[0]   = phase;
            end
            default: readdata = 32'd0;
        endcase
    end

    // Bits of the bus and timebase that this configuration does not consume.
    logic unused_ok;
`ifdef SEG7_DIMMER_BLINK_EN
    assign unused_ok = ^{writedata[31:16], tick};
`else
    assign unused_ok = ^{writedata[31:5], writedata[1], tick, frame_end};
`endif

endmodule : seg7_dimmer
